fl: RTL and testbench
=====================

# fl

Physical-register free list for the 2-way out-of-order core. Each cycle it supplies up to two free physical register tags to the map table and ROB for destination renaming (`fl_pr0`/`fl_pr1`). It takes back up to two old physical registers (`Told`) that the ROB releases at retirement. It is the producer end of the `fl_pr0`/`fl_pr1` rename interface consumed by `mt`, implemented as a circular FIFO with in-order reclaim.

## Interface
- `NUM_PR`, 64, total physical registers.
- `NUM_AR`, 32, architectural registers; PRs `0..NUM_AR-1` are architecturally mapped at reset.
- `PR_WIDTH`, 7, physical tag width.
- Derived: `CAP = NUM_PR-NUM_AR` (32) free-list slots; pointer width is `log2(CAP)` (5); count width is `log2(CAP)+1` (6).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rob_dispatch_num`  in  2  number of destination tags consumed this cycle (0, 1 or 2).
- `rob_retire_num`  in  2  number of old tags freed this cycle (0, 1 or 2).
- `rob_retire_pr0`  in  PR_WIDTH  first freed Told; valid when `rob_retire_num>=1`.
- `rob_retire_pr1`  in  PR_WIDTH  second freed Told; valid when `rob_retire_num==2`.
- `rob_mispredict`  in  1  recovery request (only present under `FL_RECOVERY_EN`).
- `fl_pr0`  out  PR_WIDTH  tag at the head slot.
- `fl_pr1`  out  PR_WIDTH  tag at slot head+1.
- `fl_free_num`  out  2  number of tags grantable this cycle: min(count, 2).

## Operation
- **Storage:** `CAP`-entry tag array, `head` pointer, `tail` pointer, and `count`.
- **Reset** (synchronous, also mid-operation):
  - `slot[i] = NUM_AR+i`, `head = 0`, `tail = 0`, `count = CAP`.
  - Outputs after reset: `fl_pr0 = 32`, `fl_pr1 = 33`, `fl_free_num = 2`.
- **Outputs:** `fl_pr0`, `fl_pr1` and `fl_free_num` are combinational reads of registered state. No dependence on same-cycle inputs.
- **Allocate:** `a = min(rob_dispatch_num, fl_free_num)`. `head += a` (mod `CAP`).
  - Requests above `fl_free_num` are illegal. They are clamped, and the simulation assertion fires.
- **Free:**
  - `rob_retire_num==1`: write `rob_retire_pr0` at `tail`.
  - `rob_retire_num==2`: write `rob_retire_pr0` at `tail` and `rob_retire_pr1` at `tail+1`.
  - Then `tail += rob_retire_num` (mod `CAP`).
  - A free that would make `count > CAP` is illegal. It is clamped, and the simulation assertion fires.
- **Simultaneous allocate and free:** `count_next = count - a + rob_retire_num`.
  - No bypass: tags freed this cycle become visible at `fl_pr0`/`fl_pr1` the next cycle at the earliest.
  - At `count == 0`, `fl_free_num = 0` even while frees arrive.
- **Wrap-around:** pointers wrap modulo `CAP`.
  - `fl_pr1` reads slot `(head+1) mod CAP`.
  - Two-tag writes straddling `CAP-1 → 0` are legal.
- **Full/empty:** `count` alone disambiguates `head == tail`.
  - `count == CAP` means full.
  - `count == 0` means empty.
- `rob_dispatch_num == 3` is treated as 2, and the assertion fires.

## Timing
- Zero-cycle grant: tags are valid in the cycle they are consumed. `mt` and the ROB latch them at the same rising edge where `head` advances.
- Free-to-reuse latency: a tag freed at edge N is presentable from cycle N+1.
- One state update per edge. No internal FSM beyond the pointer and count registers.

## Configuration
- `FL_RECOVERY_EN` defined:
  - The `rob_mispredict` port exists.
  - When it is high at an edge, retire frees of that cycle are applied first, then `head = tail_next` and `count = CAP`. All speculatively allocated tags are returned.
  - Allocation in the same cycle is ignored.
  - This works because slots `[tail, head)` still hold in-flight destination tags in program order.
- `FL_RECOVERY_EN` undefined:
  - No port and no recovery logic.
  - Mispredict recovery must be handled externally by a pipeline flush plus `reset`.

## Test plan
- **Reset:** assert `reset` for 2 cycles → `fl_pr0 = 32`, `fl_pr1 = 33`, `fl_free_num = 2`. Re-assert mid-run after 5 allocations → same values the next cycle.
- **Drain:** `rob_dispatch_num = 2` for 16 cycles → tags 32/33, 34/35 … 62/63 in order. Then `fl_free_num = 0`, and a further request grants nothing.
- **Refill and wrap:**
  - From empty, retire (0,1), (2,3) → `fl_free_num = 2`, `fl_pr0 = 0`, `fl_pr1 = 1`.
  - Dispatch 1 → `fl_pr0 = 1`, `fl_pr1 = 2`.
  - With `head = 31`, `fl_pr1` shows slot 0.
- **Simultaneous:** count 1, dispatch 1 and retire 2 (tags 5, 6) in the same cycle → this cycle `fl_free_num = 1`; next cycle `count = 2`, `fl_pr0 = 5`, `fl_pr1 = 6`.
- **Recovery (`FL_RECOVERY_EN`):**
  - After reset, dispatch 2 for 3 cycles (tags 32..37).
  - Retire 1 (tag 3). Then `rob_mispredict` together with retire 1 (tag 4).
  - Next cycle: `count = 32`, `fl_pr0 = 34`, `fl_pr1 = 35`. Tags 3 and 4 sit at slots 0 and 1.
- **Illegal:** dispatch 2 with `count = 1` → one tag consumed, `count = 0`, assertion message printed.

Source files
------------

// File: rtl/fl.sv
// fl: physical-register free list for the 2-way out-of-order core.
// A circular FIFO of free physical tags. It grants up to two tags per cycle
// from the head and takes back up to two retired Told tags at the tail.
// Optional feature macro: FL_RECOVERY_EN adds the rob_mispredict port. On a
// mispredict, every speculatively allocated tag goes back to the free list.
module fl #(
   parameter int NUM_PR   = 64,
   parameter int NUM_AR   = 32,
   parameter int PR_WIDTH = 7
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          rob_dispatch_num,
   input  logic [1:0]          rob_retire_num,
   input  logic [PR_WIDTH-1:0] rob_retire_pr0,
   input  logic [PR_WIDTH-1:0] rob_retire_pr1,
`ifdef FL_RECOVERY_EN
   input  logic                rob_mispredict,
`endif
   output logic [PR_WIDTH-1:0] fl_pr0,
   output logic [PR_WIDTH-1:0] fl_pr1,
   output logic [1:0]          fl_free_num
);

   localparam int CAP   = NUM_PR - NUM_AR;
   localparam int PTR_W = $clog2(CAP);
   localparam int CNT_W = PTR_W + 1;

   logic [PR_WIDTH-1:0] slot [CAP];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [CNT_W-1:0]    count;

   logic [PTR_W-1:0]    head_p1;
   logic [PTR_W-1:0]    tail_p1;
   logic [PTR_W-1:0]    head_next;
   logic [PTR_W-1:0]    tail_next;
   logic [CNT_W-1:0]    count_next;
   logic [1:0]          dispatch_req;
   logic [1:0]          retire_req;
   logic [1:0]          alloc_num;
   logic [1:0]          retire_num;
   logic                recover;
   int                  room;

   // Pointer increment modulo CAP, so CAP does not have to be a power of two
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                input logic [1:0] inc);
      int sum;
      sum = int'(ptr) + int'(inc);
      if (sum >= CAP) sum = sum - CAP;
      return PTR_W'(sum);
   endfunction

`ifdef FL_RECOVERY_EN
   assign recover = rob_mispredict;
`else
   assign recover = 1'b0;
`endif

   // Outputs depend only on registered state, which gives a zero-cycle grant to mt/ROB
   assign head_p1     = ptr_add(head, 2'd1);
   assign fl_pr0      = slot[head];
   assign fl_pr1      = slot[head_p1];
   assign fl_free_num = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];

   // Clamp illegal requests, then compute the next pointers and count
   always_comb begin
      dispatch_req = rob_dispatch_num;
      retire_req   = rob_retire_num;
      alloc_num    = 2'd0;
      retire_num   = 2'd0;
      room         = 0;
      if (dispatch_req == 2'd3) dispatch_req = 2'd2;
      if (retire_req == 2'd3) retire_req = 2'd2;
      alloc_num = (dispatch_req > fl_free_num) ? fl_free_num : dispatch_req;
      if (recover) alloc_num = 2'd0;
      room       = CAP - int'(count) + int'(alloc_num);
      retire_num = (int'(retire_req) > room) ? 2'(room) : retire_req;
      tail_p1    = ptr_add(tail, 2'd1);
      tail_next  = ptr_add(tail, retire_num);
      head_next  = recover ? tail_next : ptr_add(head, alloc_num);
      count_next = recover ? CNT_W'(CAP)
                           : count - CNT_W'(alloc_num) + CNT_W'(retire_num);
   end

   // State update: reset reloads tags NUM_AR..NUM_PR-1; frees write at the tail
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < CAP; i++) slot[i] <= PR_WIDTH'(NUM_AR + i);
         head  <= '0;
         tail  <= '0;
         count <= CNT_W'(CAP);
      end else begin
         if (retire_num != 2'd0) slot[tail]    <= rob_retire_pr0;
         if (retire_num == 2'd2) slot[tail_p1] <= rob_retire_pr1;
         head  <= head_next;
         tail  <= tail_next;
         count <= count_next;
      end
   end

`ifndef SYNTHESIS
   // Flag requests that had to be clamped: over-allocation, over-free, or a count of 3
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (recover || (alloc_num == rob_dispatch_num))
            else $warning("fl: dispatch request %0d clamped to %0d", rob_dispatch_num, alloc_num);
         assert (retire_num == rob_retire_num)
            else $warning("fl: retire request %0d clamped to %0d", rob_retire_num, retire_num);
      end
   end
`endif

endmodule

// File: tb/tb_fl.sv
// tb_fl: directed bench for the fl free list. A queue-based reference model
// pushes the expected outputs to a scoreboard each time stimulus is driven.
// Those values are popped and compared after the following rising edge.
module tb_fl;

   typedef struct {
      logic [6:0] pr0;
      logic [6:0] pr1;
      logic [1:0] free_num;
   } exp_t;

   logic       clock;
   logic       reset;
   logic [1:0] rob_dispatch_num;
   logic [1:0] rob_retire_num;
   logic [6:0] rob_retire_pr0;
   logic [6:0] rob_retire_pr1;
`ifdef FL_RECOVERY_EN
   logic       rob_mispredict;
`endif
   logic [6:0] fl_pr0;
   logic [6:0] fl_pr1;
   logic [1:0] fl_free_num;

   int errors = 0;
   int checks = 0;

   exp_t       sb[$];
   logic [6:0] m_free[$];
   logic [6:0] m_alloc[$];

   fl dut (
      .clock            (clock),
      .reset            (reset),
      .rob_dispatch_num (rob_dispatch_num),
      .rob_retire_num   (rob_retire_num),
      .rob_retire_pr0   (rob_retire_pr0),
      .rob_retire_pr1   (rob_retire_pr1),
`ifdef FL_RECOVERY_EN
      .rob_mispredict   (rob_mispredict),
`endif
      .fl_pr0           (fl_pr0),
      .fl_pr1           (fl_pr1),
      .fl_free_num      (fl_free_num)
   );

   // Free-running clock, period 10
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: free holds grantable tags, alloc holds in-flight tags in order
   task automatic model_reset();
      m_free.delete();
      m_alloc.delete();
      for (int i = 0; i < 32; i++) m_free.push_back(7'(32 + i));
   endtask

   task automatic model_step(input logic [1:0] d, input logic [1:0] r,
                             input logic [6:0] p0, input logic [6:0] p1, input logic m);
      int dq, rq, fn;
      logic [6:0] rt [2];
      rt[0] = p0;
      rt[1] = p1;
      dq = (d == 2'd3) ? 2 : int'(d);
      rq = (r == 2'd3) ? 2 : int'(r);
      fn = (m_free.size() < 2) ? m_free.size() : 2;
      if (dq > fn) dq = fn;
      if (m) dq = 0;
      for (int i = 0; i < dq; i++) m_alloc.push_back(m_free.pop_front());
      if (rq > m_alloc.size()) rq = m_alloc.size();
      for (int i = 0; i < rq; i++) begin
         void'(m_alloc.pop_front());
         m_free.push_back(rt[i]);
      end
      if (m) begin
         while (m_free.size() > 0) m_alloc.push_back(m_free.pop_front());
         m_free = m_alloc;
         m_alloc.delete();
      end
   endtask

   // Slots from head onward read as the free tags followed by the in-flight tags
   task automatic push_expected();
      exp_t e;
      logic [6:0] seq[$];
      seq = m_free;
      foreach (m_alloc[i]) seq.push_back(m_alloc[i]);
      e.pr0      = seq[0];
      e.pr1      = seq[1];
      e.free_num = (m_free.size() < 2) ? 2'(m_free.size()) : 2'd2;
      sb.push_back(e);
   endtask

   task automatic check_output();
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("[TB] FAIL sb_empty: observed 0 entries, expected 1");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         assert (fl_pr0 === e.pr0) else begin
            errors++;
            $error("[TB] FAIL fl_pr0: observed %0d expected %0d", fl_pr0, e.pr0);
         end
         checks++;
         assert (fl_pr1 === e.pr1) else begin
            errors++;
            $error("[TB] FAIL fl_pr1: observed %0d expected %0d", fl_pr1, e.pr1);
         end
         checks++;
         assert (fl_free_num === e.free_num) else begin
            errors++;
            $error("[TB] FAIL fl_free_num: observed %0d expected %0d", fl_free_num, e.free_num);
         end
      end
   endtask

   task automatic check_const(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, update the model, then compare after the edge
   task automatic apply_stimulus(input logic rst, input logic [1:0] d, input logic [1:0] r,
                                 input logic [6:0] p0, input logic [6:0] p1, input logic m);
      reset            = rst;
      rob_dispatch_num = d;
      rob_retire_num   = r;
      rob_retire_pr0   = p0;
      rob_retire_pr1   = p1;
`ifdef FL_RECOVERY_EN
      rob_mispredict   = m;
`endif
      if (rst) model_reset();
      else model_step(d, r, p0, p1, m);
      push_expected();
      @(posedge clock);
      @(negedge clock);
      check_output();
   endtask

   initial begin
      // Reset for two cycles
      apply_stimulus(1'b1, 2'd0, 2'd0, 7'd0, 7'd0, 1'b0);
      apply_stimulus(1'b1, 2'd0, 2'd0, 7'd0, 7'd0, 1'b0);
      check_const("rst_pr0", fl_pr0, 7'd32);
      check_const("rst_pr1", fl_pr1, 7'd33);
      check_const("rst_free_num", 7'(fl_free_num), 7'd2);

      // Five allocations, then reset mid-run
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 2'd1, 2'd0, 7'd0, 7'd0, 1'b0);
      check_const("alloc5_pr0", fl_pr0, 7'd37);
      apply_stimulus(1'b1, 2'd0, 2'd0, 7'd0, 7'd0, 1'b0);
      check_const("rerst_pr0", fl_pr0, 7'd32);
      check_const("rerst_pr1", fl_pr1, 7'd33);
      check_const("rerst_free_num", 7'(fl_free_num), 7'd2);

      // Drain by pairs, then an over-request that must grant nothing
      for (int i = 0; i < 16; i++) begin
         check_const("drain_pr0", fl_pr0, 7'(32 + 2 * i));
         check_const("drain_pr1", fl_pr1, 7'(33 + 2 * i));
         apply_stimulus(1'b0, 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      end
      check_const("empty_free_num", 7'(fl_free_num), 7'd0);
      apply_stimulus(1'b0, 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      check_const("empty_again_free_num", 7'(fl_free_num), 7'd0);

      // Refill from empty, then dispatch one
      apply_stimulus(1'b0, 2'd0, 2'd2, 7'd0, 7'd1, 1'b0);
      apply_stimulus(1'b0, 2'd0, 2'd2, 7'd2, 7'd3, 1'b0);
      check_const("refill_pr0", fl_pr0, 7'd0);
      check_const("refill_pr1", fl_pr1, 7'd1);
      check_const("refill_free_num", 7'(fl_free_num), 7'd2);
      apply_stimulus(1'b0, 2'd1, 2'd0, 7'd0, 7'd0, 1'b0);
      check_const("disp1_pr0", fl_pr0, 7'd1);
      check_const("disp1_pr1", fl_pr1, 7'd2);

      // Odd tail, then paired traffic so a two-tag write straddles slot 31 -> 0
      apply_stimulus(1'b0, 2'd0, 2'd1, 7'd4, 7'd0, 1'b0);
      for (int i = 0; i < 15; i++)
         apply_stimulus(1'b0, 2'd2, 2'd2, 7'(100 + 2 * i), 7'(101 + 2 * i), 1'b0);
      check_const("wrap_pr0", fl_pr0, 7'd126);
      check_const("wrap_pr1", fl_pr1, 7'd127);

      // Simultaneous allocate and free at count 1
      apply_stimulus(1'b1, 2'd0, 2'd0, 7'd0, 7'd0, 1'b0);
      for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      apply_stimulus(1'b0, 2'd1, 2'd0, 7'd0, 7'd0, 1'b0);
      check_const("sim_free_num_before", 7'(fl_free_num), 7'd1);
      apply_stimulus(1'b0, 2'd1, 2'd2, 7'd5, 7'd6, 1'b0);
      check_const("sim_pr0", fl_pr0, 7'd5);
      check_const("sim_pr1", fl_pr1, 7'd6);
      check_const("sim_free_num", 7'(fl_free_num), 7'd2);

      // Over-request at count 1 consumes exactly one tag
      apply_stimulus(1'b0, 2'd1, 2'd0, 7'd0, 7'd0, 1'b0);
      apply_stimulus(1'b0, 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      check_const("illegal_free_num", 7'(fl_free_num), 7'd0);

`ifdef FL_RECOVERY_EN
      // Recovery: frees land first, then head snaps to the new tail
      apply_stimulus(1'b1, 2'd0, 2'd0, 7'd0, 7'd0, 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      apply_stimulus(1'b0, 2'd0, 2'd1, 7'd3, 7'd0, 1'b0);
      apply_stimulus(1'b0, 2'd2, 2'd1, 7'd4, 7'd0, 1'b1);
      check_const("recov_pr0", fl_pr0, 7'd34);
      check_const("recov_pr1", fl_pr1, 7'd35);
      check_const("recov_free_num", 7'(fl_free_num), 7'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
